// File: rtl/alu_pipe.sv
// alu_pipe: two-stage, valid/ready handshaked ALU.
//
// Stage 1 registers the operands and opcode; stage 2 computes and registers
// the result together with the carry, zero and overflow flags.
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid && ready. A producer keeps valid high (and its payload stable)
// until the beat moves. in_ready is combinational from the pipeline state
// and out_ready, so a full pipe accepts and drains on the same edge.
//
// Build option: define ALU_SAT_EN for saturating arithmetic.
// - ADD clamps to all-ones on unsigned carry.
// - SUB clamps to zero on borrow.
// carry and ovf still report the raw arithmetic flags, and zero follows the
// clamped result. The port list is identical in both builds.
//
// OPW is fixed at 3; the opcode map below covers exactly eight codes.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             ovf
);

  localparam logic [OPW-1:0] OP_ADD   = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(1);
  localparam logic [OPW-1:0] OP_AND   = OPW'(2);
  localparam logic [OPW-1:0] OP_OR    = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(4);
  localparam logic [OPW-1:0] OP_SHL   = OPW'(5);
  localparam logic [OPW-1:0] OP_SHR   = OPW'(6);
  localparam logic [OPW-1:0] OP_PASSB = OPW'(7);

  // Stage-1 operand registers
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [OPW-1:0]   r_s1_op;

  // Stage-2 result registers
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_ovf;

  // Pipeline advance enables
  logic w_s2_adv;
  logic w_s1_adv;

  // Arithmetic is done one bit wider so the top bit is carry / borrow.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;

  // Next stage-2 values
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;

  // Stage 2 moves when it is empty or its beat is being taken this edge;
  // stage 1 moves when it is empty or stage 2 is moving.
  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};

  // Signed overflow: ADD when like-signed operands give an opposite-signed
  // sum; SUB when unlike-signed operands give a result whose sign differs
  // from the minuend.
  assign w_add_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
  assign w_sub_ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);

  // Opcode decode and result/flag computation from the stage-1 registers
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = w_add_ovf;
`ifdef ALU_SAT_EN
        if (w_sum[WIDTH]) w_res = '1;
`endif
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = w_sub_ovf;
`ifdef ALU_SAT_EN
        if (w_diff[WIDTH]) w_res = '0;
`endif
      end
      OP_AND:   w_res = r_s1_a & r_s1_b;
      OP_OR:    w_res = r_s1_a | r_s1_b;
      OP_XOR:   w_res = r_s1_a ^ r_s1_b;
      OP_SHL: begin
        w_res   = {r_s1_a[WIDTH-2:0], 1'b0};
        w_carry = r_s1_a[WIDTH-1];
      end
      OP_SHR: begin
        w_res   = {1'b0, r_s1_a[WIDTH-1:1]};
        w_carry = r_s1_a[0];
      end
      OP_PASSB: w_res = r_s1_b;
      default: begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
      end
    endcase
  end

  // Stage 1: take a new operand beat whenever the stage is free to move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a  <= a;
        r_s1_b  <= b;
        r_s1_op <= op;
      end
    end
  end

  // Stage 2: register result and flags; hold everything while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_res;
        r_carry  <= w_carry;
        r_zero   <= (w_res == '0);
        r_ovf    <= w_ovf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe (WIDTH=8).
// Inputs change 1ns after a rising edge and outputs are sampled on the
// falling edge. A scoreboard queue holds the expected {ovf,zero,carry,result}
// of every accepted beat, in order. Expected values are hand computed;
// ALU_SAT_EN selects the saturating expectations.
module tb_alu_pipe;

  localparam int W  = 8;
  localparam int EW = W + 3;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_SHL   = 3'd5;
  localparam logic [2:0] OP_SHR   = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry;
  logic          zero;
  logic          ovf;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];

  // monitor state
  logic          hold_v = 1'b0;
  logic [EW-1:0] hold_p;
  logic [EW-1:0] mon_cur;
  int            run     = 0;
  int            max_run = 0;

  alu_pipe #(.WIDTH(W), .OPW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .ovf       (ovf)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] pk(input logic [W-1:0] r, input logic c,
                                       input logic z, input logic v);
    return {v, z, c, r};
  endfunction

  // Driver: present one beat and keep it until it is accepted.
  // Starts and ends 1ns after a rising edge; in_valid is left high.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic [2:0] top, input logic [EW-1:0] texp);
    logic got;
    int   n;
    a        = ta;
    b        = tb_v;
    op       = top;
    in_valid = 1'b1;
    got      = 1'b0;
    n        = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (got) exp_q.push_back(texp);
    else chk("send_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard / monitor on the falling edge
  always @(negedge clk) begin
    mon_cur = {ovf, zero, carry, result};
    if (hold_v && rst_n) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_stable", 32'(mon_cur), 32'(hold_p));
    end
    hold_v = rst_n && out_valid && !out_ready;
    hold_p = mon_cur;
    if (out_valid) run++;
    else run = 0;
    if (run > max_run) max_run = run;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
      else chk("result", 32'(mon_cur), 32'(exp_q.pop_front()));
    end
  end

  logic [EW-1:0] e_add_f0_20, e_sub_01_02, e_sub_10_20, e_add_ff_01;

  initial begin
`ifdef ALU_SAT_EN
    e_add_f0_20 = pk(8'hFF, 1'b1, 1'b0, 1'b0);
    e_sub_01_02 = pk(8'h00, 1'b1, 1'b1, 1'b0);
    e_sub_10_20 = pk(8'h00, 1'b1, 1'b1, 1'b0);
    e_add_ff_01 = pk(8'hFF, 1'b1, 1'b0, 1'b0);
`else
    e_add_f0_20 = pk(8'h10, 1'b1, 1'b0, 1'b0);
    e_sub_01_02 = pk(8'hFF, 1'b1, 1'b0, 1'b0);
    e_sub_10_20 = pk(8'hF0, 1'b1, 1'b0, 1'b0);
    e_add_ff_01 = pk(8'h00, 1'b1, 1'b1, 1'b0);
`endif

    // reset
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({ovf, zero, carry}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single ADD with latency check
    send(8'hF0, 8'h20, OP_ADD, e_add_f0_20);
    in_valid = 1'b0;
    chk("lat1_no_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat2_valid", 32'(out_valid), 32'd1);
    chk("lat2_payload", 32'({ovf, zero, carry, result}), 32'(e_add_f0_20));
    wait_drain();

    // SUB corner cases
    send(8'h80, 8'h01, OP_SUB, pk(8'h7F, 1'b0, 1'b0, 1'b1));
    send(8'h05, 8'h05, OP_SUB, pk(8'h00, 1'b0, 1'b1, 1'b0));
    send(8'h01, 8'h02, OP_SUB, e_sub_01_02);
    in_valid = 1'b0;
    wait_drain();

    // back-to-back, one per cycle
    max_run = 0;
    send(8'h7F, 8'h01, OP_ADD,   pk(8'h80, 1'b0, 1'b0, 1'b1));
    send(8'h10, 8'h20, OP_SUB,   e_sub_10_20);
    send(8'hF0, 8'h3C, OP_AND,   pk(8'h30, 1'b0, 1'b0, 1'b0));
    send(8'h0F, 8'hA0, OP_OR,    pk(8'hAF, 1'b0, 1'b0, 1'b0));
    send(8'h55, 8'h55, OP_XOR,   pk(8'h00, 1'b0, 1'b1, 1'b0));
    send(8'h81, 8'h00, OP_SHL,   pk(8'h02, 1'b1, 1'b0, 1'b0));
    send(8'h03, 8'h00, OP_SHR,   pk(8'h01, 1'b1, 1'b0, 1'b0));
    send(8'hFF, 8'h00, OP_PASSB, pk(8'h00, 1'b0, 1'b1, 1'b0));
    in_valid = 1'b0;
    wait_drain();
    chk("b2b_run", 32'(max_run), 32'd8);

    // backpressure: stall output for 5 cycles with input pending
    out_ready = 1'b0;
    fork
      begin
        send(8'h01, 8'h02, OP_ADD, pk(8'h03, 1'b0, 1'b0, 1'b0));
        send(8'h09, 8'h03, OP_SUB, pk(8'h06, 1'b0, 1'b0, 1'b0));
        send(8'hFF, 8'h01, OP_ADD, e_add_ff_01);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_head", 32'({ovf, zero, carry, result}), 32'(pk(8'h03, 1'b0, 1'b0, 1'b0)));
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // reset with two beats in flight
    out_ready = 1'b0;
    send(8'h01, 8'h02, OP_OR,  pk(8'h03, 1'b0, 1'b0, 1'b0));
    send(8'h0F, 8'h03, OP_AND, pk(8'h03, 1'b0, 1'b0, 1'b0));
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flags", 32'({ovf, zero, carry}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", 32'(out_valid), 32'd0);
    end

    // pipe works again after reset
    send(8'hA5, 8'h5A, OP_XOR, pk(8'hFF, 1'b0, 1'b0, 1'b0));
    in_valid = 1'b0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
